// File: rtl/reorder_buffer.sv
// In-order-retire reorder buffer: allocates up to DISPATCH_W entries per
// cycle at the tail, captures results from WB_PORTS forwarding buses and
// retires up to COMMIT_W ready entries per cycle from the head.
// Occupancy lives in a dedicated counter so full and empty never depend on
// head==tail.
module reorder_buffer #(
  parameter int DEPTH      = 64,
  parameter int IDX_W      = 6,
  parameter int DISPATCH_W = 4,
  parameter int WB_PORTS   = 4,
  parameter int COMMIT_W   = 2,
  parameter int DATA_W     = 16,
  parameter int REG_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DISPATCH_W-1:0]        disp_valid,
  input  logic [DISPATCH_W*16-1:0]     disp_pc,
  input  logic [DISPATCH_W-1:0]        disp_wen,
  input  logic [DISPATCH_W*REG_W-1:0]  disp_wreg,
  output logic                         disp_ready,
  output logic [DISPATCH_W*IDX_W-1:0]  disp_idx,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]    wb_idx,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
  input  logic                         flush,
  output logic [COMMIT_W-1:0]          commit_valid,
  output logic [COMMIT_W-1:0]          commit_wen,
  output logic [COMMIT_W*REG_W-1:0]    commit_wreg,
  output logic [COMMIT_W*DATA_W-1:0]   commit_data,
  output logic [COMMIT_W*16-1:0]       commit_pc,
  output logic [IDX_W:0]               count
);

  localparam int PC_W = 16;
  // Highest occupancy that still leaves room for a full dispatch group.
  localparam logic [IDX_W:0] READY_MAX = (IDX_W+1)'(DEPTH - DISPATCH_W);
  localparam logic [IDX_W:0] ONE = (IDX_W+1)'(1);

  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [DEPTH-1:0]  entValid;
  logic [DEPTH-1:0]  entReady;
  logic [DEPTH-1:0]  entWen;
  logic [PC_W-1:0]   entPc   [DEPTH];
  logic [REG_W-1:0]  entWreg [DEPTH];
  logic [DATA_W-1:0] entData [DEPTH];

  logic              dispFire;
  logic [IDX_W:0]    nDisp;
  logic [IDX_W:0]    nCommit;
  logic [IDX_W:0]    countNext;
  logic              run;
  logic [IDX_W-1:0]  cIdx;

  // Dispatch side: readiness from registered count only, lane indices from tail.
  always_comb begin
    disp_ready = (count <= READY_MAX);
    dispFire   = disp_ready & ~flush;
    nDisp      = '0;
    disp_idx   = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      disp_idx[i*IDX_W +: IDX_W] = tail + IDX_W'(i);
      if (dispFire && disp_valid[i]) nDisp = nDisp + ONE;
    end
  end

  // Commit lanes: a lane retires only if it and every older lane are valid and ready.
  always_comb begin
    run          = ~flush;
    nCommit      = '0;
    cIdx         = head;
    commit_valid = '0;
    commit_wen   = '0;
    commit_wreg  = '0;
    commit_data  = '0;
    commit_pc    = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      cIdx = head + IDX_W'(k);
      run  = run & entValid[cIdx] & entReady[cIdx];
      commit_valid[k] = run;
      if (run) begin
        commit_wen[k]                     = entWen[cIdx];
        commit_wreg[k*REG_W +: REG_W]     = entWreg[cIdx];
        commit_data[k*DATA_W +: DATA_W]   = entData[cIdx];
        commit_pc[k*PC_W +: PC_W]         = entPc[cIdx];
        nCommit                           = nCommit + ONE;
      end
    end
    countNext = count + nDisp - nCommit;
  end

  // Control state: pointers, occupancy and per-entry valid/ready bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      entValid <= '0;
      entReady <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      entValid <= '0;
      entReady <= '0;
    end else begin
      tail  <= tail + nDisp[IDX_W-1:0];
      head  <= head + nCommit[IDX_W-1:0];
      count <= countNext;
      for (int i = 0; i < DISPATCH_W; i++) begin
        if (dispFire && disp_valid[i]) begin
          entValid[tail + IDX_W'(i)] <= 1'b1;
          entReady[tail + IDX_W'(i)] <= 1'b0;
        end
      end
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && entValid[wb_idx[p*IDX_W +: IDX_W]])
          entReady[wb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
      end
      // Retirement clears last so it overrides a writeback to the same entry.
      for (int k = 0; k < COMMIT_W; k++) begin
        if (commit_valid[k]) begin
          entValid[head + IDX_W'(k)] <= 1'b0;
          entReady[head + IDX_W'(k)] <= 1'b0;
        end
      end
    end
  end

  // Entry payload: no reset needed, it is only observed through valid/ready.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DISPATCH_W; i++) begin
      if (dispFire && disp_valid[i]) begin
        entPc[tail + IDX_W'(i)]   <= disp_pc[i*PC_W +: PC_W];
        entWen[tail + IDX_W'(i)]  <= disp_wen[i];
        entWreg[tail + IDX_W'(i)] <= disp_wreg[i*REG_W +: REG_W];
      end
    end
    // Later ports overwrite earlier ones, so the highest-numbered port wins.
    for (int p = 0; p < WB_PORTS; p++) begin
      if (!flush && wb_valid[p] && entValid[wb_idx[p*IDX_W +: IDX_W]])
        entData[wb_idx[p*IDX_W +: IDX_W]] <= wb_data[p*DATA_W +: DATA_W];
    end
  end

endmodule
